// File: rtl/du_regs_sender.sv
// Dumps the whole register file over the UART TX FIFO as one framed byte stream:
// SOT, every register LSB first, then EOT, pacing each write on the FIFO full flag.
module du_regs_sender #(
    parameter int NB_REG_DATA  = 32,
    parameter int NB_UART_DATA = 8,
    parameter int NB_REG_ADDR  = 5
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [NB_REG_DATA-1:0]  i_reg_data,
    input  logic                    i_tx_full,
    output logic [NB_REG_ADDR-1:0]  o_reg_addr,
    output logic                    o_wr,
    output logic [NB_UART_DATA-1:0] o_wdata,
    output logic                    o_tx_start,
    output logic                    o_done
);

    localparam int N_BYTES = NB_REG_DATA / NB_UART_DATA;
    localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [NB_BCNT-1:0]      LAST_BYTE = NB_BCNT'(N_BYTES - 1);
    localparam logic [NB_REG_ADDR-1:0]  LAST_REG  = {NB_REG_ADDR{1'b1}};
    localparam logic [NB_UART_DATA-1:0] SOT_BYTE  = NB_UART_DATA'(8'h01);
    localparam logic [NB_UART_DATA-1:0] EOT_BYTE  = NB_UART_DATA'(8'h04);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND_SOT  = 3'd1;
    localparam logic [2:0] ST_LOAD      = 3'd2;
    localparam logic [2:0] ST_SEND_BYTE = 3'd3;
    localparam logic [2:0] ST_SEND_EOT  = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    logic [2:0]              state_reg,   state_next;
    logic [NB_REG_ADDR-1:0]  reg_cnt_reg, reg_cnt_next;
    logic [NB_BCNT-1:0]      byte_cnt_reg, byte_cnt_next;
    logic [NB_REG_DATA-1:0]  data_sr_reg, data_sr_next;

    logic                    wr;
    logic [NB_UART_DATA-1:0] wdata;
    logic                    done;

    always_comb begin
        state_next    = state_reg;
        reg_cnt_next  = reg_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        data_sr_next  = data_sr_reg;
        wr            = 1'b0;
        wdata         = '0;
        done          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next    = ST_SEND_SOT;
                    reg_cnt_next  = '0;
                    byte_cnt_next = '0;
                end
            end
            ST_SEND_SOT: begin
                if (!i_tx_full) begin
                    wr         = 1'b1;
                    wdata      = SOT_BYTE;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_sr_next  = i_reg_data;
                byte_cnt_next = '0;
                state_next    = ST_SEND_BYTE;
            end
            ST_SEND_BYTE: begin
                // A full FIFO freezes the shifter and counters so the byte is retried, not lost.
                if (!i_tx_full) begin
                    wr            = 1'b1;
                    wdata         = data_sr_reg[NB_UART_DATA-1:0];
                    data_sr_next  = data_sr_reg >> NB_UART_DATA;
                    byte_cnt_next = byte_cnt_reg + 1'b1;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        if (reg_cnt_reg == LAST_REG) begin
                            state_next = ST_SEND_EOT;
                        end else begin
                            reg_cnt_next = reg_cnt_reg + 1'b1;
                            state_next   = ST_LOAD;
                        end
                    end
                end
            end
            ST_SEND_EOT: begin
                if (!i_tx_full) begin
                    wr         = 1'b1;
                    wdata      = EOT_BYTE;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (!i_start) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            reg_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            data_sr_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            reg_cnt_reg  <= reg_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            data_sr_reg  <= data_sr_next;
        end
    end

    // Outputs are masked by reset itself so they read zero in the very first reset cycle.
    assign o_wr       = wr & ~i_rst;
    assign o_tx_start = wr & ~i_rst;
    assign o_wdata    = i_rst ? '0 : wdata;
    assign o_done     = done & ~i_rst;
    assign o_reg_addr = i_rst ? '0 : reg_cnt_reg;

endmodule

// File: tb/tb_du_regs_sender.sv
// Randomized bench for du_regs_sender: frames are compared against a byte-queue
// model of the register dump and a slot-walking model of the completion cycle.
module tb_du_regs_sender;

    localparam int NB_REG_DATA  = 32;
    localparam int NB_UART_DATA = 8;
    localparam int NB_REG_ADDR  = 5;
    localparam int N_REGS       = 2 ** NB_REG_ADDR;
    localparam int MAX_CYC      = 3000;

    logic                    clk = 1'b0;
    logic                    i_rst;
    logic                    i_start;
    logic [NB_REG_DATA-1:0]  i_reg_data;
    logic                    i_tx_full;
    logic [NB_REG_ADDR-1:0]  o_reg_addr;
    logic                    o_wr;
    logic [NB_UART_DATA-1:0] o_wdata;
    logic                    o_tx_start;
    logic                    o_done;

    du_regs_sender #(
        .NB_REG_DATA (NB_REG_DATA),
        .NB_UART_DATA(NB_UART_DATA),
        .NB_REG_ADDR (NB_REG_ADDR)
    ) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_reg_data(i_reg_data),
        .i_tx_full (i_tx_full),
        .o_reg_addr(o_reg_addr),
        .o_wr      (o_wr),
        .o_wdata   (o_wdata),
        .o_tx_start(o_tx_start),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    logic [NB_REG_DATA-1:0] regs [N_REGS];
    always_comb i_reg_data = regs[o_reg_addr];

    int   n_vec = 0;
    int   n_err = 0;
    bit   full_pat [MAX_CYC];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int   viol_full, viol_txs, viol_wd;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic build_expected();
        exp_q.delete();
        exp_q.push_back(8'h01);
        for (int r = 0; r < N_REGS; r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(regs[r][8*b +: 8]);
        exp_q.push_back(8'h04);
    endtask

    // Each write slot waits out full cycles then takes one cycle; each word load takes one cycle.
    function automatic int model_done_cycle();
        int t = 1;
        while (full_pat[t]) t++;
        t++;
        for (int r = 0; r < N_REGS; r++) begin
            t++;
            for (int b = 0; b < 4; b++) begin
                while (full_pat[t]) t++;
                t++;
            end
        end
        while (full_pat[t]) t++;
        t++;
        return t;
    endfunction

    task automatic run_frame(input int full_pct, input int start_cycles, input int hold_after,
                             input int stop_at, output int done_cyc, output int done_len,
                             output int exp_cyc);
        bit finished = 1'b0;
        got_q.delete();
        done_cyc  = -1;
        done_len  = 0;
        viol_full = 0;
        viol_txs  = 0;
        viol_wd   = 0;
        for (int i = 0; i < MAX_CYC; i++) full_pat[i] = ($urandom_range(99) < full_pct);
        full_pat[0] = 1'b0;
        exp_cyc = model_done_cycle();
        for (int c = 0; c < MAX_CYC; c++) begin
            @(posedge clk);
            #1;
            if (start_cycles > 0) i_start = (c < start_cycles);
            else                  i_start = (done_cyc < 0) || (c <= done_cyc + hold_after);
            i_tx_full = full_pat[c];
            @(negedge clk);
            if (o_wr) got_q.push_back(o_wdata);
            if (o_wr && i_tx_full)   viol_full++;
            if (o_tx_start !== o_wr) viol_txs++;
            if (!o_wr && o_wdata != 0) viol_wd++;
            if (o_done) begin
                if (done_cyc < 0) done_cyc = c;
                done_len++;
            end
            if (stop_at > 0 && got_q.size() >= stop_at) begin
                finished = 1'b1;
                break;
            end
            if (done_cyc >= 0 && !o_done) begin
                finished = 1'b1;
                break;
            end
        end
        i_start   = 1'b0;
        i_tx_full = 1'b0;
        check_val("frame_end", 32'(finished), 32'd1);
        check_val("wr_while_full", viol_full, 0);
        check_val("tx_start_eq_wr", viol_txs, 0);
        check_val("wdata_idle_zero", viol_wd, 0);
    endtask

    task automatic check_stream(input string name, input int n);
        check_val({name, "_len"}, got_q.size(), n);
        for (int i = 0; i < got_q.size() && i < n; i++)
            check_val($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
    endtask

    task automatic check_frame(input string name, input int done_cyc, input int done_len,
                               input int exp_cyc, input int exp_len);
        check_stream(name, exp_q.size());
        check_val({name, "_done_cycle"}, done_cyc, exp_cyc);
        check_val({name, "_done_len"}, done_len, exp_len);
        $display("%s: %0d bytes, done at cycle %0d (model %0d), done high %0d cycles",
                 name, got_q.size(), done_cyc, exp_cyc, done_len);
    endtask

    task automatic reset_cycle(input string name, input bit rst);
        @(posedge clk);
        #1;
        i_rst     = rst;
        i_start   = 1'b0;
        i_tx_full = 1'b0;
        @(negedge clk);
        check_val({name, "_wr"}, o_wr, 0);
        check_val({name, "_tx_start"}, o_tx_start, 0);
        check_val({name, "_wdata"}, o_wdata, 0);
        check_val({name, "_done"}, o_done, 0);
        check_val({name, "_reg_addr"}, o_reg_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, dl, ec;
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_tx_full = 1'b0;
        for (int r = 0; r < N_REGS; r++) regs[r] = 32'h11223300 + 32'(r);

        for (int k = 0; k < 3; k++) reset_cycle("init_rst", 1'b1);
        reset_cycle("init_post", 1'b0);
        $display("reset: outputs idle");

        // Reference frame, no backpressure.
        build_expected();
        run_frame(0, 0, 0, 0, dc, dl, ec);
        check_frame("plain", dc, dl, ec, 2);
        check_val("plain_done_163", dc, 163);

        // Random backpressure at ~50%.
        run_frame(50, 0, 0, 0, dc, dl, ec);
        check_frame("backpressure", dc, dl, ec, 2);

        // Reset after the 50th byte, then a fresh frame.
        run_frame(40, 0, 0, 50, dc, dl, ec);
        check_stream("pre_reset", 50);
        for (int k = 0; k < 3; k++) reset_cycle("mid_rst", 1'b1);
        reset_cycle("mid_post", 1'b0);
        for (int k = 0; k < 5; k++) reset_cycle("no_resume", 1'b0);
        $display("mid-frame reset after %0d bytes", got_q.size());
        run_frame(30, 0, 0, 0, dc, dl, ec);
        check_frame("after_reset", dc, dl, ec, 2);

        // Start held for 20 cycles past done: one frame, DONE until start falls.
        run_frame(0, 0, 20, 0, dc, dl, ec);
        check_frame("hold_start", dc, dl, ec, 22);

        // Start dropped after 10 cycles: frame still completes, DONE for one cycle.
        run_frame(25, 10, 0, 0, dc, dl, ec);
        check_frame("early_drop", dc, dl, ec, 1);

        // Random register contents with extreme corner words.
        for (int r = 0; r < N_REGS; r++) regs[r] = $urandom;
        regs[0]          = 32'hFFFFFFFF;
        regs[N_REGS - 1] = 32'hDEADBEEF;
        build_expected();
        run_frame(50, 0, 0, 0, dc, dl, ec);
        check_frame("corner_regs", dc, dl, ec, 2);
        if (got_q.size() == 130) begin
            check_val("first_after_sot0", got_q[1], 8'hFF);
            check_val("first_after_sot3", got_q[4], 8'hFF);
            check_val("last_before_eot0", got_q[125], 8'hEF);
            check_val("last_before_eot1", got_q[126], 8'hBE);
            check_val("last_before_eot2", got_q[127], 8'hAD);
            check_val("last_before_eot3", got_q[128], 8'hDE);
            check_val("eot", got_q[129], 8'h04);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
